fetch_stage: RTL
================

# fetch_stage

Instruction-fetch stage of the pipelined microprocessor: owns the program counter, drives the synchronous instruction memory, and presents one {pc, instr} word per cycle to the IF/ID pipeline register directly downstream. It honours a stall from the hazard unit by holding its output stable, and a taken branch/jump redirect from EX with a one-bubble penalty. Bubbles are driven as all-zero words, which the downstream register treats as a NOP.

## Interface
- PC_WIDTH, 10, PC / instruction-memory address width (word addressed)
- INSTR_WIDTH, 32, instruction width
- RESET_PC, 0, first address fetched after reset
- PC_STEP, 1, PC increment per sequential fetch
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high
- stall  in  1  downstream will not capture this cycle; hold output
- redirect  in  1  taken branch/jump resolved in EX this cycle
- redirect_pc  in  PC_WIDTH  target address, valid when redirect=1
- imem_en  out  1  instruction-memory read enable
- imem_addr  out  PC_WIDTH  read address; data returns on imem_rdata next cycle
- imem_rdata  in  INSTR_WIDTH  read data for address issued previous cycle
- if_valid  out  1  if_pc/if_instr hold a real instruction
- if_pc  out  PC_WIDTH  address of presented instruction; 0 when !if_valid
- if_instr  out  INSTR_WIDTH  presented instruction; 0 when !if_valid
- if_bundle  out  PC_WIDTH+INSTR_WIDTH  {if_pc, if_instr}; feeds the IF/ID register (42 bits at defaults)
- fetch_count  out  16  instructions accepted downstream (if_valid && !stall), wraps at 2^16

## Operation
- Registers: fpc (next sequential address), pc_q (address of word in flight/held), v_q (in-flight word valid), hold_instr, state, fetch_count.
- States: BOOT, RUN, HOLD.
- BOOT (entered on reset): if_valid=0; imem_en=1, imem_addr=RESET_PC; pc_q<=RESET_PC, v_q<=1, fpc<=RESET_PC+PC_STEP; -> RUN. Stall ignored. A redirect in BOOT is handled as in RUN.
- RUN: output = {pc_q, imem_rdata} gated by v_q.
  - redirect: if_valid forced 0; imem_addr=redirect_pc (combinational), imem_en=1; pc_q<=redirect_pc, v_q<=1, fpc<=redirect_pc+PC_STEP; stay RUN.
  - else stall, v_q=1: hold_instr<=imem_rdata; imem_en=0; fpc, pc_q unchanged; -> HOLD.
  - else stall, v_q=0: imem_en=0; v_q<=0; stay RUN.
  - else: imem_addr=fpc, imem_en=1; pc_q<=fpc, v_q<=1, fpc<=fpc+PC_STEP.
- HOLD: output = {pc_q, hold_instr}, if_valid=1.
  - redirect: if_valid forced 0; issue redirect_pc as in RUN; -> RUN.
  - else stall: imem_en=0; stay HOLD.
  - else: issue fpc as in RUN; -> RUN.
- Priority: reset > redirect > stall > advance.
- When imem_en=0, imem_addr=fpc.
- PC arithmetic is modulo 2^PC_WIDTH, so fpc wraps from all-ones to 0 with no flag.
- fetch_count increments in any cycle with if_valid=1 and stall=0, including the HOLD exit cycle. It does not increment on squashed (redirect) cycles.

## Timing
- Reset values: if_valid 0, if_pc 0, if_instr 0, if_bundle 0, imem_en 0 while reset high, imem_addr RESET_PC, fetch_count 0, state BOOT, fpc RESET_PC.
- Startup: reset deasserts before edge E0 (BOOT). First valid output (pc=RESET_PC) appears in the cycle after E0.
- Sequential latency: address issued cycle N, instruction presented cycle N+1.
- Redirect penalty: exactly one invalid cycle (the redirect cycle). Target is presented the next cycle.
- Stall: output bit-identical for every stalled cycle. No memory read is issued while stalled. The next sequential instruction appears the cycle after the stall deasserts.
- Reset mid-operation: immediate asynchronous clear to reset values. In-flight and held words are discarded.

## Structure
- Shared package pipe_pkg: PC_WIDTH, INSTR_WIDTH, RESET_PC, NOP word (all zeros), fetch-state enum {BOOT, RUN, HOLD}.
- No sub-module. The downstream IF/ID register is instantiated by the core top-level, not inside this block.

## Test plan
- Reset release, no stall, memory returns instr = 0x1000_0000 + addr. Required: cycle 1 if_valid=0; then if_pc=0,1,2,3 with matching instr. fetch_count=3 after 3 accepted.
- Stall for 3 cycles while pc=2 is presented, memory output corrupted during stall. Required: if_pc=2, instr=0x1000_0002 held all 3 cycles; then pc=3; no imem_en during stall.
- redirect=1, redirect_pc=0x100 while pc=5 is presented. Required: that cycle if_valid=0 and imem_addr=0x100; next cycles pc=0x100, 0x101.
- redirect and stall together while in HOLD. Required: redirect wins; squash cycle, then pc=redirect_pc; fetch_count unchanged in the squash cycle.
- fpc at 0x3FF (PC_WIDTH=10), sequential run. Required: pc sequence 0x3FE, 0x3FF, 0x000.
- Reset asserted mid-stream in HOLD. Required: outputs zero immediately; after release, refetch from RESET_PC with the BOOT bubble.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline types and constants: PC/instruction widths, the NOP word,
// the fetch-state encoding and the IF/ID payload layout.
package pipe_pkg;

    localparam int unsigned PC_WIDTH    = 10;
    localparam int unsigned INSTR_WIDTH = 32;
    localparam int unsigned CNT_WIDTH   = 16;

    typedef logic [PC_WIDTH-1:0]    pc_t;
    typedef logic [INSTR_WIDTH-1:0] instr_t;

    localparam pc_t    RESET_PC  = PC_WIDTH'(0);
    localparam pc_t    PC_STEP   = PC_WIDTH'(1);
    localparam instr_t NOP_INSTR = INSTR_WIDTH'(0);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;

    typedef struct packed {
        pc_t    pc;
        instr_t instr;
    } if_bundle_t;

    // Wraps modulo 2^PC_WIDTH by construction.
    function automatic pc_t pc_next(input pc_t pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage signal bundle: hazard/EX controls, instruction-memory port and
// the word presented to the IF/ID register.
interface fetch_stage_if;
    import pipe_pkg::*;

    logic                 stall;
    logic                 redirect;
    pc_t                  redirect_pc;
    logic                 imem_en;
    pc_t                  imem_addr;
    instr_t               imem_rdata;
    logic                 if_valid;
    pc_t                  if_pc;
    instr_t               if_instr;
    if_bundle_t           if_bundle;
    logic [CNT_WIDTH-1:0] fetch_count;

    modport master (
        input  stall, redirect, redirect_pc, imem_rdata,
        output imem_en, imem_addr, if_valid, if_pc, if_instr, if_bundle, fetch_count
    );

    modport slave (
        output stall, redirect, redirect_pc, imem_rdata,
        input  imem_en, imem_addr, if_valid, if_pc, if_instr, if_bundle, fetch_count
    );

endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the synchronous instruction
// memory and presents one {pc, instr} word per cycle, honouring stall/redirect.
module fetch_stage
    import pipe_pkg::*;
(
    input logic           clk,
    input logic           reset,
    fetch_stage_if.master bus
);

    fetch_state_e         state_q, state_d;
    pc_t                  fpc_q, fpc_d;
    pc_t                  pc_q, pc_d;
    logic                 v_q, v_d;
    instr_t               hold_instr_q, hold_instr_d;
    logic [CNT_WIDTH-1:0] fetch_count_q, fetch_count_d;

    logic   issue_c;
    pc_t    issue_pc_c;
    logic   en_c;
    pc_t    addr_c;
    logic   valid_c;
    instr_t instr_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= BOOT;
            fpc_q         <= RESET_PC;
            pc_q          <= RESET_PC;
            v_q           <= 1'b0;
            hold_instr_q  <= NOP_INSTR;
            fetch_count_q <= CNT_WIDTH'(0);
        end else begin
            state_q       <= state_d;
            fpc_q         <= fpc_d;
            pc_q          <= pc_d;
            v_q           <= v_d;
            hold_instr_q  <= hold_instr_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    // Next state, memory request and presented word; redirect beats stall.
    always_comb begin
        state_d      = state_q;
        fpc_d        = fpc_q;
        pc_d         = pc_q;
        v_d          = v_q;
        hold_instr_d = hold_instr_q;
        issue_c      = 1'b0;
        issue_pc_c   = fpc_q;
        en_c         = 1'b0;
        addr_c       = fpc_q;
        valid_c      = 1'b0;
        instr_c      = bus.imem_rdata;

        unique case (state_q)
            BOOT: begin
                issue_c    = 1'b1;
                issue_pc_c = bus.redirect ? bus.redirect_pc : RESET_PC;
                state_d    = RUN;
            end
            RUN: begin
                valid_c = v_q && !bus.redirect;
                if (bus.redirect) begin
                    issue_c    = 1'b1;
                    issue_pc_c = bus.redirect_pc;
                end else if (bus.stall) begin
                    if (v_q) begin
                        hold_instr_d = bus.imem_rdata;
                        state_d      = HOLD;
                    end else begin
                        v_d = 1'b0;
                    end
                end else begin
                    issue_c = 1'b1;
                end
            end
            HOLD: begin
                valid_c = !bus.redirect;
                instr_c = hold_instr_q;
                if (bus.redirect) begin
                    issue_c    = 1'b1;
                    issue_pc_c = bus.redirect_pc;
                    state_d    = RUN;
                end else if (!bus.stall) begin
                    issue_c = 1'b1;
                    state_d = RUN;
                end
            end
            default: state_d = BOOT;
        endcase

        if (issue_c) begin
            en_c   = 1'b1;
            addr_c = issue_pc_c;
            pc_d   = issue_pc_c;
            v_d    = 1'b1;
            fpc_d  = pc_next(issue_pc_c);
        end

        fetch_count_d = fetch_count_q + CNT_WIDTH'(valid_c && !bus.stall);
    end

    // Memory-side and IF/ID-side outputs; invalid words are forced to the NOP pattern.
    assign bus.imem_en     = en_c && !reset;
    assign bus.imem_addr   = reset ? RESET_PC : addr_c;
    assign bus.if_valid    = valid_c;
    assign bus.if_pc       = valid_c ? pc_q : RESET_PC & PC_WIDTH'(0);
    assign bus.if_instr    = valid_c ? instr_c : NOP_INSTR;
    assign bus.if_bundle   = '{pc: bus.if_pc, instr: bus.if_instr};
    assign bus.fetch_count = fetch_count_q;

endmodule
